// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, write ports, reserve port and status.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] ra3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] rd3;
  logic              busy1;
  logic              busy2;
  logic              busy3;
  logic [DATA_W-1:0] pc_in;
  logic              we_a;
  logic [ADDR_W-1:0] wa_a;
  logic [DATA_W-1:0] wd_a;
  logic              we_b;
  logic [ADDR_W-1:0] wa_b;
  logic [DATA_W-1:0] wd_b;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              ready;
  logic              collision_err;

  modport slave (
    input  ra1, ra2, ra3, pc_in,
    input  we_a, wa_a, wd_a, we_b, wa_b, wd_b, rsv_en, rsv_addr,
    output rd1, rd2, rd3, busy1, busy2, busy3, ready, collision_err
  );

  modport master (
    output ra1, ra2, ra3, pc_in,
    output we_a, wa_a, wd_a, we_b, wa_b, wd_b, rsv_en, rsv_addr,
    input  rd1, rd2, rd3, busy1, busy2, busy3, ready, collision_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Decode-stage register file: 3 combinational reads, ALU and load write ports,
// per-register load scoreboard, and a sequential clear engine run after reset.
// The top index aliases the externally supplied PC+8 value.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int PC_IDX = NREGS - 1,
  parameter int BYPASS = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  regfile_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] PC_ADDR   = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic [ADDR_W-1:0]   w_init_cnt_nxt;
  logic                r_ready;
  logic                r_coll;
  logic [NREGS-1:0]    r_sb;
  logic [DATA_W-1:0]   r_mem [NREGS];

  logic                w_init_we;
  logic                w_op_en;
  logic                w_wr_a;
  logic                w_wr_b;
  logic                w_coll;
  logic                w_rsv;
  logic [ADDR_W-1:0]   w_ra   [3];
  logic [DATA_W-1:0]   w_rd   [3];
  logic                w_busy [3];

  assign w_ra[0] = bus.ra1;
  assign w_ra[1] = bus.ra2;
  assign w_ra[2] = bus.ra3;

  // State register: FSM state, clear-engine pointer and the ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= {ADDR_W{1'b0}};
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_ready    <= (w_state_nxt == ST_READY);
    end
  end

  // Next-state logic: walk every entry once, then stay READY until reset.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        w_init_cnt_nxt = r_init_cnt + ADDR_W'(1);
        if (r_init_cnt == LAST_ADDR) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt    = ST_INIT;
        w_init_cnt_nxt = {ADDR_W{1'b0}};
      end
    endcase
  end

  // FSM outputs: clear-engine write strobe and normal-operation enable.
  always_comb begin
    w_init_we = 1'b0;
    w_op_en   = 1'b0;
    case (r_state)
      ST_INIT:  w_init_we = 1'b1;
      ST_READY: w_op_en   = 1'b1;
      default: begin
        w_init_we = 1'b0;
        w_op_en   = 1'b0;
      end
    endcase
  end

  // Qualified write/reserve strobes; PC alias never takes writes or reserves.
  always_comb begin
    w_wr_a = w_op_en & bus.we_a & (bus.wa_a != PC_ADDR);
    w_wr_b = w_op_en & bus.we_b & (bus.wa_b != PC_ADDR);
    w_coll = w_wr_a & w_wr_b & (bus.wa_a == bus.wa_b);
    w_rsv  = w_op_en & bus.rsv_en & (bus.rsv_addr != PC_ADDR);
  end

  // Storage: zeroed entry by entry during INIT, port A wins a same-address clash.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[r_init_cnt] <= {DATA_W{1'b0}};
    end else begin
      if (w_wr_b && !w_coll) begin
        r_mem[bus.wa_b] <= bus.wd_b;
      end
      if (w_wr_a) begin
        r_mem[bus.wa_a] <= bus.wd_a;
      end
    end
  end

  // Scoreboard: load return clears, load issue sets; set applied last so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb <= {NREGS{1'b0}};
    end else begin
      if (w_wr_b) begin
        r_sb[bus.wa_b] <= 1'b0;
      end
      if (w_rsv) begin
        r_sb[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  // Sticky collision flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll <= 1'b0;
    end else if (w_coll) begin
      r_coll <= 1'b1;
    end
  end

  // Read ports: PC alias, zero during INIT, otherwise storage with optional forwarding.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      w_rd[n]   = {DATA_W{1'b0}};
      w_busy[n] = 1'b0;
      if (w_ra[n] == PC_ADDR) begin
        w_rd[n]   = bus.pc_in;
        w_busy[n] = 1'b0;
      end else if (!w_op_en) begin
        w_rd[n]   = {DATA_W{1'b0}};
        w_busy[n] = 1'b0;
      end else begin
        w_rd[n]   = r_mem[w_ra[n]];
        w_busy[n] = r_sb[w_ra[n]];
        if (BYPASS != 0) begin
          if (w_wr_a && (bus.wa_a == w_ra[n])) begin
            w_rd[n] = bus.wd_a;
          end else if (w_wr_b && (bus.wa_b == w_ra[n])) begin
            w_rd[n] = bus.wd_b;
          end else begin
            w_rd[n] = r_mem[w_ra[n]];
          end
          if (w_wr_b && (bus.wa_b == w_ra[n]) &&
              !(w_rsv && (bus.rsv_addr == w_ra[n]))) begin
            w_busy[n] = 1'b0;
          end else begin
            w_busy[n] = r_sb[w_ra[n]];
          end
        end else begin
          w_rd[n]   = r_mem[w_ra[n]];
          w_busy[n] = r_sb[w_ra[n]];
        end
      end
    end
  end

  assign bus.rd1           = w_rd[0];
  assign bus.rd2           = w_rd[1];
  assign bus.rd3           = w_rd[2];
  assign bus.busy1         = w_busy[0];
  assign bus.busy2         = w_busy[1];
  assign bus.busy3         = w_busy[2];
  assign bus.ready         = r_ready;
  assign bus.collision_err = r_coll;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core register file. It provides three combinational read ports, two clocked write ports (ALU writeback and long-latency load writeback), and a per-register scoreboard that flags registers with an outstanding load. A sequential clear engine zeroes the storage after reset. It sits in the decode stage; the PC-alias index reads the externally supplied PC+8 value.

Parameters:
DATA_W, 32, register width in bits
NREGS, 16, number of architectural registers (power of 2, >=4)
ADDR_W, $clog2(NREGS), register address width (derived, do not override)
PC_IDX, NREGS-1, index aliased to pc_in; no storage used for it
BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads see stored value only

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ra1, ra2, ra3  in  ADDR_W  read addresses
rd1, rd2, rd3  out  DATA_W  read data (combinational)
busy1, busy2, busy3  out  1  scoreboard pending flag for ra1..ra3
pc_in  in  DATA_W  value returned for reads of PC_IDX (PC+8, computed externally)
we_a  in  1  write enable, port A (ALU)
wa_a  in  ADDR_W  write address, port A
wd_a  in  DATA_W  write data, port A
we_b  in  1  write enable, port B (load return); also clears the scoreboard bit
wa_b  in  ADDR_W  write address, port B
wd_b  in  DATA_W  write data, port B
rsv_en  in  1  reserve: set scoreboard bit at rsv_addr (load issued)
rsv_addr  in  ADDR_W  register to reserve
ready  out  1  storage initialised; writes and reserves accepted
collision_err  out  1  sticky: port A and port B wrote the same address in one cycle

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM enters INIT; init counter set to 0.
  - All scoreboard bits cleared; ready=0; collision_err=0.
  - Storage array is not reset.
- INIT state:
  - Each rising edge writes 0 to entry init_cnt, then increments init_cnt.
  - After the edge that clears entry NREGS-1, FSM goes to READY and ready=1. Exactly NREGS edges after rst_n rises.
  - In INIT, we_a, we_b and rsv_en are ignored.
  - rdN = 0 and busyN = 0 for every address except PC_IDX.
- READY state:
  - Holds until the next reset. rst_n assertion mid-INIT or in READY restarts INIT from 0.
- Reads (all states):
  - raN == PC_IDX gives rdN = pc_in and busyN = 0.
  - Otherwise rdN = storage[raN], subject to bypass.
  - BYPASS=1, READY: if raN matches an enabled write this cycle, rdN = that write's data (port A has priority if both match).
- Writes (READY, rising edge):
  - we_a writes wd_a to wa_a; we_b writes wd_b to wa_b.
  - Writes to PC_IDX are discarded.
  - If both write the same non-PC address, port A data is stored and collision_err is set (stays 1 until reset).
- Scoreboard (READY, rising edge):
  - rsv_en sets sb[rsv_addr]; we_b clears sb[wa_b].
  - Same address in the same cycle: set wins.
  - rsv_en to PC_IDX is ignored. we_a does not affect sb.
  - busyN = sb[raN].
  - BYPASS=1: busyN is forced 0 when we_b targets raN this cycle and no rsv_en targets raN.
- Latency:
  - Stored write is visible one cycle after the edge (zero cycles with bypass).
  - Scoreboard set is visible the cycle after rsv_en.

Test Plan:
- Init: release rst_n, hold we_a=1, wa_a=3, wd_a=0xFFFF_FFFF -> ready=0 for 16 edges, rises after the 16th edge; then read r3 -> 0x0000_0000 (write ignored).
- Basic/PC: READY, we_a writes r5=0x1234_5678 -> rd1(ra1=5)=0x1234_5678 same cycle (BYPASS=1) and next cycle; rd2(ra2=15) = pc_in = 0x0000_0108; writing r15 leaves rd2 = pc_in.
- Scoreboard: rsv_en r7 -> busy1(ra1=7)=1 next cycle; 4 cycles later we_b r7=0xCAFE_0000 -> busy1=0 and rd1=0xCAFE_0000 in the same cycle; busy stays 0 afterwards.
- Set/clear race: sb[2]=1, same cycle rsv_en r2 and we_b r2 -> sb[2] stays 1, r2 holds wd_b.
- Collision: we_a r9=0xAAAA_AAAA and we_b r9=0x5555_5555 in one cycle -> r9=0xAAAA_AAAA, collision_err=1 and stays 1 until rst_n.
- Mid-op reset: pulse rst_n low asynchronously (between edges) while sb[4]=1 -> busy, ready, collision_err drop immediately; new INIT takes 16 edges; r4 reads 0 afterwards.
